// File: rtl/mem_fu_nb.sv
// Non-blocking load/store unit: pending-load slots with line fill and CDB writeback.
// Stores resolve combinationally into the store queue.
package mem_fu_pkg;
    typedef enum logic [3:0] {
        LOAD_BYTE,
        LOAD_HALF,
        LOAD_WORD,
        LOAD_DOUBLE,
        LOAD_BYTE_U,
        LOAD_HALF_U,
        STORE_BYTE,
        STORE_HALF,
        STORE_WORD,
        STORE_DOUBLE
    } MEM_FUNC;

    typedef enum logic [1:0] {
        FREE,
        WAIT,
        READY
    } slot_st_e;
endpackage

module mem_fu_nb
    import mem_fu_pkg::*;
#(
    parameter int NUM_PENDING = 4,
    parameter int TAG_W       = 6,
    parameter int SQ_W        = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             valid,
    input  MEM_FUNC          func,
    input  logic [31:0]      rs1,
    input  logic [31:0]      rs2,
    input  logic [31:0]      imm,
    input  logic [TAG_W-1:0] dest_tag,
    input  logic [SQ_W-1:0]  sq_idx,
    input  logic             flush,
    input  logic             cache_resp_valid,
    input  logic [31:0]      cache_resp_addr,
    input  logic [63:0]      cache_resp_data,
    input  logic             cdb_grant,
    output logic             full,
    output logic             dcache_req_valid,
    output logic [31:0]      dcache_req_addr,
    output logic             sq_valid,
    output logic [31:0]      sq_addr,
    output logic [31:0]      sq_data,
    output logic [SQ_W-1:0]  sq_idx_out,
    output logic             cdb_request,
    output logic [TAG_W-1:0] cdb_tag,
    output logic [31:0]      cdb_data
);
    localparam int IW = (NUM_PENDING > 1) ? $clog2(NUM_PENDING) : 1;

    slot_st_e         state_q [NUM_PENDING];
    slot_st_e         state_d [NUM_PENDING];
    logic [TAG_W-1:0] tag_q   [NUM_PENDING];
    logic [TAG_W-1:0] tag_d   [NUM_PENDING];
    logic [31:0]      addr_q  [NUM_PENDING];
    logic [31:0]      addr_d  [NUM_PENDING];
    MEM_FUNC          func_q  [NUM_PENDING];
    MEM_FUNC          func_d  [NUM_PENDING];
    logic [31:0]      data_q  [NUM_PENDING];
    logic [31:0]      data_d  [NUM_PENDING];
    logic [IW-1:0]    req_ptr_q, req_ptr_d;
    logic             req_hold_q, req_hold_d;

    logic [31:0]      eff_addr;
    logic             is_load, is_store;
    logic             any_free, any_wait, any_ready;
    logic [IW-1:0]    free_idx, wait_idx, ready_idx, req_idx;
    logic             alloc_en, grant_en;
    logic             unused_resp_lsb;

    assign eff_addr        = rs1 + imm;
    assign unused_resp_lsb = ^cache_resp_addr[2:0];

    function automatic logic [31:0] extract(
        input MEM_FUNC     f,
        input logic [31:0] a,
        input logic [63:0] line
    );
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        w = a[2] ? line[63:32] : line[31:0];
        b = w[{a[1:0], 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f)
            LOAD_BYTE:   extract = {{24{b[7]}}, b};
            LOAD_BYTE_U: extract = {24'd0, b};
            LOAD_HALF:   extract = {{16{h[15]}}, h};
            LOAD_HALF_U: extract = {16'd0, h};
            default:     extract = w;
        endcase
    endfunction

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        case (func)
            LOAD_BYTE, LOAD_HALF, LOAD_WORD,
            LOAD_DOUBLE, LOAD_BYTE_U, LOAD_HALF_U: is_load = 1'b1;
            STORE_BYTE, STORE_HALF,
            STORE_WORD, STORE_DOUBLE:              is_store = 1'b1;
            default: ;
        endcase
    end

    // Descending scan leaves the lowest matching index in each *_idx.
    always_comb begin
        any_free  = 1'b0;
        any_wait  = 1'b0;
        any_ready = 1'b0;
        free_idx  = '0;
        wait_idx  = '0;
        ready_idx = '0;
        for (int i = NUM_PENDING - 1; i >= 0; i--) begin
            if (state_q[i] == FREE) begin
                any_free = 1'b1;
                free_idx = IW'(i);
            end
            if (state_q[i] == WAIT) begin
                any_wait = 1'b1;
                wait_idx = IW'(i);
            end
            if (state_q[i] == READY) begin
                any_ready = 1'b1;
                ready_idx = IW'(i);
            end
        end
    end

    // Keep requesting the same line until its slot leaves WAIT.
    always_comb begin
        if (req_hold_q && state_q[req_ptr_q] == WAIT)
            req_idx = req_ptr_q;
        else
            req_idx = wait_idx;
        req_ptr_d  = req_idx;
        req_hold_d = any_wait;
    end

    assign full             = !any_free;
    assign alloc_en         = valid && is_load && any_free && !flush;
    assign grant_en         = any_ready && cdb_grant;
    assign dcache_req_valid = any_wait;
    assign dcache_req_addr  = any_wait ? {addr_q[req_idx][31:3], 3'b000} : '0;
    assign cdb_request      = any_ready;
    assign cdb_tag          = any_ready ? tag_q[ready_idx] : '0;
    assign cdb_data         = any_ready ? data_q[ready_idx] : '0;
    assign sq_valid         = valid && is_store;
    assign sq_addr          = sq_valid ? eff_addr : '0;
    assign sq_data          = sq_valid ? rs2 : '0;
    assign sq_idx_out       = sq_valid ? sq_idx : '0;

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        addr_d  = addr_q;
        func_d  = func_q;
        data_d  = data_q;
        if (flush) begin
            for (int i = 0; i < NUM_PENDING; i++)
                state_d[i] = FREE;
        end else begin
            if (cache_resp_valid) begin
                for (int i = 0; i < NUM_PENDING; i++) begin
                    if (state_q[i] == WAIT &&
                        addr_q[i][31:3] == cache_resp_addr[31:3]) begin
                        state_d[i] = READY;
                        data_d[i]  = extract(func_q[i], addr_q[i],
                                             cache_resp_data);
                    end
                end
            end
            if (grant_en)
                state_d[ready_idx] = FREE;
            if (alloc_en) begin
                state_d[free_idx] = WAIT;
                tag_d[free_idx]   = dest_tag;
                addr_d[free_idx]  = eff_addr;
                func_d[free_idx]  = func;
                data_d[free_idx]  = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_PENDING; i++) begin
                state_q[i] <= FREE;
                tag_q[i]   <= '0;
                addr_q[i]  <= '0;
                func_q[i]  <= LOAD_BYTE;
                data_q[i]  <= '0;
            end
            req_ptr_q  <= '0;
            req_hold_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            addr_q     <= addr_d;
            func_q     <= func_d;
            data_q     <= data_d;
            req_ptr_q  <= req_ptr_d;
            req_hold_q <= req_hold_d;
        end
    end
endmodule

// File: tb/tb_mem_fu_nb.sv
// Directed bench for mem_fu_nb with a CDB scoreboard queue.
// Expected load results are queued at issue and compared at grant.
module tb_mem_fu_nb;
    import mem_fu_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        valid = 1'b0;
    MEM_FUNC     func = LOAD_WORD;
    logic [31:0] rs1 = '0, rs2 = '0, imm = '0;
    logic [5:0]  dest_tag = '0;
    logic [2:0]  sq_idx = '0;
    logic        flush = 1'b0;
    logic        cache_resp_valid = 1'b0;
    logic [31:0] cache_resp_addr = '0;
    logic [63:0] cache_resp_data = '0;
    logic        cdb_grant = 1'b0;

    logic        full, dcache_req_valid, sq_valid, cdb_request;
    logic [31:0] dcache_req_addr, sq_addr, sq_data, cdb_data;
    logic [2:0]  sq_idx_out;
    logic [5:0]  cdb_tag;

    mem_fu_nb dut (
        .clock            (clock),
        .reset            (reset),
        .valid            (valid),
        .func             (func),
        .rs1              (rs1),
        .rs2              (rs2),
        .imm              (imm),
        .dest_tag         (dest_tag),
        .sq_idx           (sq_idx),
        .flush            (flush),
        .cache_resp_valid (cache_resp_valid),
        .cache_resp_addr  (cache_resp_addr),
        .cache_resp_data  (cache_resp_data),
        .cdb_grant        (cdb_grant),
        .full             (full),
        .dcache_req_valid (dcache_req_valid),
        .dcache_req_addr  (dcache_req_addr),
        .sq_valid         (sq_valid),
        .sq_addr          (sq_addr),
        .sq_data          (sq_data),
        .sq_idx_out       (sq_idx_out),
        .cdb_request      (cdb_request),
        .cdb_tag          (cdb_tag),
        .cdb_data         (cdb_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [5:0]  tag;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic issue(input MEM_FUNC f, input logic [31:0] base,
                         input logic [31:0] off, input logic [5:0] tag,
                         input logic [31:0] expd);
        exp_t e;
        valid    = 1'b1;
        func     = f;
        rs1      = base;
        imm      = off;
        dest_tag = tag;
        e.tag    = tag;
        e.data   = expd;
        sb.push_back(e);
        step();
        valid = 1'b0;
    endtask

    task automatic resp(input logic [31:0] a, input logic [63:0] d);
        cache_resp_valid = 1'b1;
        cache_resp_addr  = a;
        cache_resp_data  = d;
        step();
        cache_resp_valid = 1'b0;
    endtask

    task automatic collect(input string name);
        exp_t e;
        int   w;
        w = 0;
        while (!cdb_request && w < 20) begin
            step();
            w++;
        end
        if (!cdb_request) begin
            chk({name, "_req_timeout"}, 64'(cdb_request), 64'd1);
            return;
        end
        chk({name, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk({name, "_tag"}, 64'(cdb_tag), 64'(e.tag));
        chk({name, "_data"}, 64'(cdb_data), 64'(e.data));
        cdb_grant = 1'b1;
        step();
        cdb_grant = 1'b0;
    endtask

    always @(posedge clock) begin
        if (!reset && valid && full &&
            func inside {LOAD_BYTE, LOAD_HALF, LOAD_WORD,
                         LOAD_DOUBLE, LOAD_BYTE_U, LOAD_HALF_U}) begin
            errors++;
            $error("FAIL illegal_load issued while full");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        // reset
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("rst_full", 64'(full), 0);
        chk("rst_req", 64'(dcache_req_valid), 0);
        chk("rst_cdb_req", 64'(cdb_request), 0);
        chk("rst_cdb_tag", 64'(cdb_tag), 0);
        chk("rst_cdb_data", 64'(cdb_data), 0);

        // store resolves in the same cycle
        valid  = 1'b1;
        func   = STORE_WORD;
        rs1    = 32'h40;
        imm    = 32'hFFFF_FFF8;
        rs2    = 32'hDEAD;
        sq_idx = 3'd3;
        #1;
        chk("st_valid", 64'(sq_valid), 1);
        chk("st_addr", 64'(sq_addr), 64'h38);
        chk("st_data", 64'(sq_data), 64'hDEAD);
        chk("st_idx", 64'(sq_idx_out), 3);
        chk("st_no_cdb", 64'(cdb_request), 0);
        step();
        valid = 1'b0;
        #1;
        chk("st_idle_valid", 64'(sq_valid), 0);
        chk("st_no_slot", 64'(dcache_req_valid), 0);

        // single miss
        issue(LOAD_WORD, 32'h1000, 32'd4, 6'd5, 32'hAAAA_AAAA);
        chk("miss_req", 64'(dcache_req_valid), 1);
        chk("miss_addr", 64'(dcache_req_addr), 64'h1000);
        cache_resp_valid = 1'b1;
        cache_resp_addr  = 32'h1000;
        cache_resp_data  = 64'hAAAA_AAAA_1122_3344;
        #1;
        chk("miss_no_hit_path", 64'(cdb_request), 0);
        step();
        cache_resp_valid = 1'b0;
        collect("miss");
        chk("miss_freed_cdb", 64'(cdb_request), 0);
        chk("miss_freed_req", 64'(dcache_req_valid), 0);

        // sign and zero extension
        issue(LOAD_BYTE, 32'h1000, 32'd3, 6'd1, 32'hFFFF_FF80);
        issue(LOAD_BYTE_U, 32'h1000, 32'd3, 6'd2, 32'h0000_0080);
        issue(LOAD_HALF, 32'h1000, 32'd2, 6'd3, 32'hFFFF_80FF);
        resp(32'h1000, 64'h0000_0000_80FF_FF7F);
        collect("ext_lb");
        collect("ext_lbu");
        collect("ext_lh");

        // full, then fill and grant in the same cycle
        issue(LOAD_WORD, 32'h3000, 32'd0, 6'd10, 32'h1000_000A);
        chk("full_e1", 64'(full), 0);
        issue(LOAD_WORD, 32'h3040, 32'd0, 6'd11, 32'h1000_000B);
        issue(LOAD_WORD, 32'h3080, 32'd0, 6'd12, 32'h1000_000C);
        chk("full_e3", 64'(full), 0);
        issue(LOAD_WORD, 32'h30C0, 32'd0, 6'd13, 32'h1000_000D);
        chk("full_e4", 64'(full), 1);
        chk("full_req0", 64'(dcache_req_addr), 64'h3000);
        resp(32'h3000, 64'h0000_0000_1000_000A);
        chk("full_ready_still", 64'(full), 1);
        chk("full_cdb_req", 64'(cdb_request), 1);
        chk("full_req1", 64'(dcache_req_addr), 64'h3040);
        e = sb.pop_front();
        chk("fg_tag", 64'(cdb_tag), 64'(e.tag));
        chk("fg_data", 64'(cdb_data), 64'(e.data));
        cdb_grant        = 1'b1;
        cache_resp_valid = 1'b1;
        cache_resp_addr  = 32'h3040;
        cache_resp_data  = 64'h0000_0000_1000_000B;
        #1;
        chk("fg_full_same_cycle", 64'(full), 1);
        step();
        cdb_grant        = 1'b0;
        cache_resp_valid = 1'b0;
        chk("fg_full_after", 64'(full), 0);
        chk("fg_next_tag", 64'(cdb_tag), 11);
        chk("full_req2", 64'(dcache_req_addr), 64'h3080);
        resp(32'h3080, 64'h0000_0000_1000_000C);
        chk("full_req3", 64'(dcache_req_addr), 64'h30C0);
        resp(32'h30C0, 64'h0000_0000_1000_000D);
        collect("full_t11");
        collect("full_t12");
        collect("full_t13");

        // multi-slot fill with held grant
        issue(LOAD_WORD, 32'h2000, 32'd0, 6'd1, 32'h1111_1111);
        issue(LOAD_WORD, 32'h2004, 32'd0, 6'd2, 32'h2222_2222);
        resp(32'h2000, 64'h2222_2222_1111_1111);
        chk("mf_no_wait", 64'(dcache_req_valid), 0);
        for (int k = 0; k < 3; k++) begin
            chk("mf_hold_tag", 64'(cdb_tag), 1);
            chk("mf_hold_data", 64'(cdb_data), 64'h1111_1111);
            step();
        end
        collect("mf_t1");
        collect("mf_t2");

        // flush drops pending loads and a same-cycle load
        issue(LOAD_WORD, 32'h4000, 32'd0, 6'd20, 32'h0);
        issue(LOAD_WORD, 32'h4040, 32'd0, 6'd21, 32'h0);
        issue(LOAD_WORD, 32'h4080, 32'd0, 6'd22, 32'h0);
        repeat (3) void'(sb.pop_back());
        chk("fl_req_before", 64'(dcache_req_valid), 1);
        valid    = 1'b1;
        func     = LOAD_WORD;
        rs1      = 32'h5000;
        imm      = 32'd0;
        dest_tag = 6'd23;
        flush    = 1'b1;
        step();
        valid = 1'b0;
        flush = 1'b0;
        chk("fl_req_after", 64'(dcache_req_valid), 0);
        chk("fl_full", 64'(full), 0);
        valid  = 1'b1;
        flush  = 1'b1;
        func   = STORE_BYTE;
        rs1    = 32'h100;
        imm    = 32'd1;
        rs2    = 32'h55;
        sq_idx = 3'd5;
        #1;
        chk("fl_store_valid", 64'(sq_valid), 1);
        chk("fl_store_addr", 64'(sq_addr), 64'h101);
        step();
        valid = 1'b0;
        flush = 1'b0;
        resp(32'h4000, 64'h1234_5678_9ABC_DEF0);
        resp(32'h5000, 64'h1234_5678_9ABC_DEF0);
        chk("fl_no_cdb", 64'(cdb_request), 0);
        step();
        chk("fl_no_cdb_later", 64'(cdb_request), 0);

        // reset during a miss
        valid    = 1'b1;
        func     = LOAD_WORD;
        rs1      = 32'h6000;
        imm      = 32'd0;
        dest_tag = 6'd30;
        step();
        valid = 1'b0;
        chk("rm_req", 64'(dcache_req_valid), 1);
        reset            = 1'b1;
        flush            = 1'b1;
        cdb_grant        = 1'b1;
        step();
        reset     = 1'b0;
        flush     = 1'b0;
        cdb_grant = 1'b0;
        chk("rm_req_cleared", 64'(dcache_req_valid), 0);
        chk("rm_full", 64'(full), 0);
        chk("rm_cdb_tag", 64'(cdb_tag), 0);
        resp(32'h6000, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rm_no_cdb", 64'(cdb_request), 0);
        chk("rm_cdb_data", 64'(cdb_data), 0);

        chk("sb_empty_end", 64'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
